// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for channel arbiters
// Purpose: arbiter FSM state encoding and channel-id width helpers.
// Ports: none (package).
package arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_DRAIN,
    WR_DRAIN
  } arb_state_t;

  localparam int NUM_CHANNELS_DFLT = 4;
  localparam int CH_ID_BITS        = $clog2(NUM_CHANNELS_DFLT);

  // Width of a channel index; never less than one bit.
  function automatic int ch_id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: returns the first requester at or above rr_ptr, wrapping modulo N.
// Ports:
//   req     in  N     request vector
//   rr_ptr  in  IW    highest-priority index
//   any     out 1     at least one request present
//   idx     out IW    chosen index (0 when any=0)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one external memory port
// Purpose: serialises per-channel read/write requests onto a single external
//   port, one transaction at a time, using a 4-phase valid/ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   ch_read_valid/address, ch_read_ready/data      per-channel read side
//   ch_write_valid/address/data, ch_write_ready    per-channel write side
//   ext_read_*/ext_write_*                         external memory port
//   busy, grant_id                                 status
module mem_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           ch_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address,
  output logic [NUM_CHANNELS-1:0]           ch_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data,
  input  logic [NUM_CHANNELS-1:0]           ch_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data,
  output logic [NUM_CHANNELS-1:0]           ch_write_ready,
  output logic                              ext_read_valid,
  output logic [ADDR_BITS-1:0]              ext_read_address,
  input  logic                              ext_read_ready,
  input  logic [DATA_BITS-1:0]              ext_read_data,
  output logic                              ext_write_valid,
  output logic [ADDR_BITS-1:0]              ext_write_address,
  output logic [DATA_BITS-1:0]              ext_write_data,
  input  logic                              ext_write_ready,
  output logic                              busy,
  output logic [$clog2(NUM_CHANNELS)-1:0]   grant_id
);

  localparam int IDW = ch_id_bits(NUM_CHANNELS);

  arb_state_t              state_q, state_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                    busy_q, busy_d;
  logic                    ext_rd_valid_q, ext_rd_valid_d;
  logic                    ext_wr_valid_q, ext_wr_valid_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [DATA_BITS-1:0]    rd_data_q, rd_data_d;
  // Set once the granted channel's read has returned; keeps its data visible
  // after ready drops and stops a write grant from exposing stale read data.
  logic                    rd_own_q, rd_own_d;
  logic [NUM_CHANNELS-1:0] ch_rd_ready_q, ch_rd_ready_d;
  logic [NUM_CHANNELS-1:0] ch_wr_ready_q, ch_wr_ready_d;

  logic [NUM_CHANNELS-1:0] req;
  logic                    pick_any;
  logic [IDW-1:0]          pick_idx;
  logic [IDW-1:0]          next_ptr;

  assign req      = ch_read_valid | ch_write_valid;
  assign next_ptr = (grant_q == IDW'(NUM_CHANNELS - 1)) ? '0 : grant_q + 1'b1;

  rr_pick #(.N(NUM_CHANNELS)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    busy_d         = busy_q;
    ext_rd_valid_d = ext_rd_valid_q;
    ext_wr_valid_d = ext_wr_valid_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_data_d      = rd_data_q;
    rd_own_d       = rd_own_q;
    ch_rd_ready_d  = ch_rd_ready_q;
    ch_wr_ready_d  = ch_wr_ready_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          busy_d   = 1'b1;
          rd_own_d = 1'b0;
          // A channel asserting both read and write is served read-first.
          if (ch_read_valid[pick_idx]) begin
            addr_d         = ch_read_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
            ext_rd_valid_d = 1'b1;
            state_d        = RD_WAIT;
          end else begin
            addr_d         = ch_write_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
            wdata_d        = ch_write_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
            ext_wr_valid_d = 1'b1;
            state_d        = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (ext_read_ready) begin
          ext_rd_valid_d         = 1'b0;
          rd_data_d              = ext_read_data;
          rd_own_d               = 1'b1;
          ch_rd_ready_d[grant_q] = 1'b1;
          state_d                = RD_DRAIN;
        end
      end
      WR_WAIT: begin
        if (ext_write_ready) begin
          ext_wr_valid_d         = 1'b0;
          ch_wr_ready_d[grant_q] = 1'b1;
          state_d                = WR_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (!ch_read_valid[grant_q] && !ext_read_ready) begin
          ch_rd_ready_d = '0;
          busy_d        = 1'b0;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end
      end
      WR_DRAIN: begin
        if (!ch_write_valid[grant_q] && !ext_write_ready) begin
          ch_wr_ready_d = '0;
          busy_d        = 1'b0;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      busy_q         <= 1'b0;
      ext_rd_valid_q <= 1'b0;
      ext_wr_valid_q <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_data_q      <= '0;
      rd_own_q       <= 1'b0;
      ch_rd_ready_q  <= '0;
      ch_wr_ready_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      busy_q         <= busy_d;
      ext_rd_valid_q <= ext_rd_valid_d;
      ext_wr_valid_q <= ext_wr_valid_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_data_q      <= rd_data_d;
      rd_own_q       <= rd_own_d;
      ch_rd_ready_q  <= ch_rd_ready_d;
      ch_wr_ready_q  <= ch_wr_ready_d;
    end
  end

  // Only the granted channel ever sees read data; all other slices stay 0.
  always_comb begin
    ch_read_data = '0;
    if (rd_own_q) ch_read_data[int'(grant_q)*DATA_BITS +: DATA_BITS] = rd_data_q;
  end

  assign ch_read_ready     = ch_rd_ready_q;
  assign ch_write_ready    = ch_wr_ready_q;
  assign ext_read_valid    = ext_rd_valid_q;
  assign ext_read_address  = addr_q;
  assign ext_write_valid   = ext_wr_valid_q;
  assign ext_write_address = addr_q;
  assign ext_write_data    = wdata_q;
  assign busy              = busy_q;
  assign grant_id          = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ch_read_valid = '0;
  logic [31:0] ch_read_address = '0;
  logic [3:0]  ch_read_ready;
  logic [31:0] ch_read_data;
  logic [3:0]  ch_write_valid = '0;
  logic [31:0] ch_write_address = '0;
  logic [31:0] ch_write_data = '0;
  logic [3:0]  ch_write_ready;
  logic        ext_read_valid;
  logic [7:0]  ext_read_address;
  logic        ext_read_ready = 1'b0;
  logic [7:0]  ext_read_data = '0;
  logic        ext_write_valid;
  logic [7:0]  ext_write_address;
  logic [7:0]  ext_write_data;
  logic        ext_write_ready = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.NUM_CHANNELS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .ch_read_valid     (ch_read_valid),
    .ch_read_address   (ch_read_address),
    .ch_read_ready     (ch_read_ready),
    .ch_read_data      (ch_read_data),
    .ch_write_valid    (ch_write_valid),
    .ch_write_address  (ch_write_address),
    .ch_write_data     (ch_write_data),
    .ch_write_ready    (ch_write_ready),
    .ext_read_valid    (ext_read_valid),
    .ext_read_address  (ext_read_address),
    .ext_read_ready    (ext_read_ready),
    .ext_read_data     (ext_read_data),
    .ext_write_valid   (ext_write_valid),
    .ext_write_address (ext_write_address),
    .ext_write_data    (ext_write_data),
    .ext_write_ready   (ext_write_ready),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serves one granted transaction from the memory side and checks both ends.
  task automatic serve(input string tag, input int ch, input bit is_rd,
                       input logic [7:0] addr, input logic [7:0] dat,
                       input int lat, input bit drop, input bit reassert);
    for (int k = 0; k < 10 && !(ext_read_valid || ext_write_valid); k++) step();
    if (!(ext_read_valid || ext_write_valid)) begin
      check({tag, "_grant_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_grant"}, 32'(grant_id), 32'(ch));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_rd_valid"}, 32'(ext_read_valid), 32'(is_rd));
    check({tag, "_wr_valid"}, 32'(ext_write_valid), 32'(!is_rd));
    if (is_rd) check({tag, "_rd_addr"}, 32'(ext_read_address), 32'(addr));
    else begin
      check({tag, "_wr_addr"}, 32'(ext_write_address), 32'(addr));
      check({tag, "_wr_data"}, 32'(ext_write_data), 32'(dat));
    end
    for (int k = 0; k < lat; k++) begin
      step();
      check({tag, "_ext_excl"}, 32'(ext_read_valid & ext_write_valid), 32'd0);
    end
    if (is_rd) begin
      ext_read_ready = 1'b1;
      ext_read_data  = dat;
    end else ext_write_ready = 1'b1;
    step();
    if (is_rd) begin
      check({tag, "_ch_rd_ready"}, 32'(ch_read_ready), 32'(1) << ch);
      check({tag, "_ch_wr_ready0"}, 32'(ch_write_ready), 32'd0);
      check({tag, "_ch_rd_data"}, ch_read_data, 32'(dat) << (8 * ch));
      check({tag, "_ext_rd_drop"}, 32'(ext_read_valid), 32'd0);
    end else begin
      check({tag, "_ch_wr_ready"}, 32'(ch_write_ready), 32'(1) << ch);
      check({tag, "_ch_rd_ready0"}, 32'(ch_read_ready), 32'd0);
      check({tag, "_ext_wr_drop"}, 32'(ext_write_valid), 32'd0);
    end
    ext_read_ready  = 1'b0;
    ext_write_ready = 1'b0;
    if (drop) begin
      if (is_rd) ch_read_valid[ch] = 1'b0;
      else ch_write_valid[ch] = 1'b0;
      step();
      check({tag, "_drain_busy"}, 32'(busy), 32'd0);
      check({tag, "_drain_ready"}, 32'({ch_read_ready, ch_write_ready}), 32'd0);
      if (reassert) begin
        if (is_rd) ch_read_valid[ch] = 1'b1;
        else ch_write_valid[ch] = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ext_valid", 32'({ext_read_valid, ext_write_valid}), 32'd0);
    check("rst_ready", 32'({ch_read_ready, ch_write_ready}), 32'd0);
    check("rst_rd_data", ch_read_data, 32'd0);
    reset = 1'b1;
    step();

    // Single read on ch1
    ch_read_address[15:8] = 8'h3A;
    ch_read_valid[1] = 1'b1;
    check("t1_no_early_valid", 32'(ext_read_valid), 32'd0);
    step();
    check("t1_issue_latency", 32'(ext_read_valid), 32'd1);
    serve("t1", 1, 1'b1, 8'h3A, 8'h5C, 2, 1'b1, 1'b0);
    check("t1_data_hold", ch_read_data, 32'h0000_5C00);

    // Round-robin from a fresh rr_ptr=0 with all channels reading
    reset = 1'b0;
    step();
    reset = 1'b1;
    ch_read_address = 32'h4342_4140;
    ch_read_valid   = 4'hF;
    serve("rr0", 0, 1'b1, 8'h40, 8'h80, 1, 1'b1, 1'b1);
    serve("rr1", 1, 1'b1, 8'h41, 8'h81, 1, 1'b1, 1'b1);
    serve("rr2", 2, 1'b1, 8'h42, 8'h82, 1, 1'b1, 1'b1);
    serve("rr3", 3, 1'b1, 8'h43, 8'h83, 1, 1'b1, 1'b1);
    serve("rr0w", 0, 1'b1, 8'h40, 8'h90, 1, 1'b1, 1'b0);
    ch_read_valid = 4'h0;
    step();
    check("rr_idle", 32'(busy), 32'd0);

    // Same-channel read+write on ch2: read first, write next grant
    ch_read_address[23:16]  = 8'h10;
    ch_write_address[23:16] = 8'h11;
    ch_write_data[23:16]    = 8'hAA;
    ch_read_valid[2]  = 1'b1;
    ch_write_valid[2] = 1'b1;
    serve("rw_rd", 2, 1'b1, 8'h10, 8'h33, 1, 1'b1, 1'b0);
    serve("rw_wr", 2, 1'b0, 8'h11, 8'hAA, 2, 1'b1, 1'b0);

    // Mixed contention with rr_ptr=3: ch3 read then ch0 write
    ch_write_address[7:0]  = 8'h20;
    ch_write_data[7:0]     = 8'h7F;
    ch_read_address[31:24] = 8'h21;
    ch_write_valid[0] = 1'b1;
    ch_read_valid[3]  = 1'b1;
    serve("mx_rd3", 3, 1'b1, 8'h21, 8'h44, 2, 1'b1, 1'b0);
    serve("mx_wr0", 0, 1'b0, 8'h20, 8'h7F, 2, 1'b1, 1'b0);

    // Slow drain on ch1 (rr_ptr=1) with ch2 competing
    ch_read_address[15:8]  = 8'h55;
    ch_read_address[23:16] = 8'h66;
    ch_read_valid[1] = 1'b1;
    ch_read_valid[2] = 1'b1;
    serve("sd1", 1, 1'b1, 8'h55, 8'h99, 1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("sd_hold_busy", 32'(busy), 32'd1);
      check("sd_hold_grant", 32'(grant_id), 32'd1);
      check("sd_hold_no_issue", 32'({ext_read_valid, ext_write_valid}), 32'd0);
      check("sd_hold_ready", 32'(ch_read_ready), 32'h2);
    end
    ch_read_valid[1] = 1'b0;
    step();
    check("sd_release_busy", 32'(busy), 32'd0);
    check("sd_release_ready", 32'(ch_read_ready), 32'd0);
    serve("sd2", 2, 1'b1, 8'h66, 8'h12, 0, 1'b1, 1'b0);

    // Reset during RD_WAIT
    ch_read_address[15:8] = 8'h77;
    ch_read_valid[1] = 1'b1;
    step();
    step();
    check("mr_in_wait", 32'(ext_read_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mr_async_rd_valid", 32'(ext_read_valid), 32'd0);
    check("mr_async_busy", 32'(busy), 32'd0);
    check("mr_async_grant", 32'(grant_id), 32'd0);
    check("mr_async_ready", 32'({ch_read_ready, ch_write_ready}), 32'd0);
    ch_read_valid = 4'h0;
    step();
    reset = 1'b1;
    ch_read_address[7:0]   = 8'h01;
    ch_read_address[31:24] = 8'h03;
    ch_read_valid[0] = 1'b1;
    ch_read_valid[3] = 1'b1;
    serve("mr_ch0", 0, 1'b1, 8'h01, 8'hE0, 1, 1'b1, 1'b0);
    serve("mr_ch3", 3, 1'b1, 8'h03, 8'hE3, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between NUM_CHANNELS cache-controller channels.
- Sits between the cache's per-channel read/write request lines and global memory, where external bandwidth is a single port.
- Round-robin fair and one transaction in flight at a time.
- Uses the codebase 4-phase valid/ready handshake on both sides: valid held until ready; ready held until valid drops.

Parameters:
- NUM_CHANNELS, 4, number of requesting channels (≥2).
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, memory bus width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_read_valid  in  NUM_CHANNELS  per-channel read request.
- ch_read_address  in  NUM_CHANNELS×ADDR_BITS  read address.
- ch_read_ready  out  NUM_CHANNELS  read complete, data valid.
- ch_read_data  out  NUM_CHANNELS×DATA_BITS  read data.
- ch_write_valid  in  NUM_CHANNELS  per-channel write request.
- ch_write_address  in  NUM_CHANNELS×ADDR_BITS  write address.
- ch_write_data  in  NUM_CHANNELS×DATA_BITS  write data.
- ch_write_ready  out  NUM_CHANNELS  write complete.
- ext_read_valid  out  1  external read request.
- ext_read_address  out  ADDR_BITS  external read address.
- ext_read_ready  in  1  external read done.
- ext_read_data  in  DATA_BITS  external read data.
- ext_write_valid  out  1  external write request.
- ext_write_address  out  ADDR_BITS  external write address.
- ext_write_data  out  DATA_BITS  external write data.
- ext_write_ready  in  1  external write done.
- busy  out  1  transaction in progress.
- grant_id  out  $clog2(NUM_CHANNELS)  channel currently granted.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, rr_ptr=0, rd_data_q=0.
- Request per channel c is req[c] = ch_read_valid[c] | ch_write_valid[c]. If both are set on the same channel, the read is served first; the write is then served in a later grant.
- Pick: first c with req[c], searching upward from rr_ptr with wrap-around modulo NUM_CHANNELS. rr_ptr itself has highest priority.
- States:
  - IDLE: if any req, register grant_id=c, busy=1, and the operation type, then drive the ext address/data (and write data) and valid. Next state is RD_WAIT or WR_WAIT. The ext valid is visible the cycle after the request is sampled (1-cycle issue latency).
  - RD_WAIT: on ext_read_ready, do the following and go to RD_DRAIN:
    - ext_read_valid<=0;
    - rd_data_q<=ext_read_data;
    - ch_read_data[grant_id]<=ext_read_data;
    - ch_read_ready[grant_id]<=1.
  - WR_WAIT: on ext_write_ready, set ext_write_valid<=0 and ch_write_ready[grant_id]<=1; go to WR_DRAIN.
  - RD_DRAIN / WR_DRAIN: wait until the granted channel's valid=0 AND the matching ext ready=0. Then:
    - clear ch_*_ready[grant_id];
    - busy<=0;
    - rr_ptr<=(grant_id+1) mod NUM_CHANNELS (wraps NUM_CHANNELS-1→0);
    - go to IDLE.
    - ch_read_data[grant_id] holds its value after ready drops.
- Address, data and the grant are latched at issue. The channel must hold its inputs stable until it sees ready; later changes are ignored.
- The granted channel's valid dropping while in RD_WAIT or WR_WAIT is a protocol violation. The arbiter still completes the ext transaction and the drain.
- Minimum occupancy per transaction: 1 issue cycle + memory latency + 1 drain cycle. There are no back-to-back issues without passing through IDLE.
- At most one of ext_read_valid or ext_write_valid is high at any time. At most one ch_*_ready bit is high at any time.
- Non-granted channels' outputs stay 0.
- Reset asserted mid-transaction aborts immediately: ext valid drops asynchronously, and no channel ready is produced.

Decomposition:
- Shared package arbiter_pkg:
  - arb_state_t enum (IDLE, RD_WAIT, WR_WAIT, RD_DRAIN, WR_DRAIN);
  - localparam CH_ID_BITS=$clog2(NUM_CHANNELS) helper.
- Sub-module rr_pick (combinational):
  - inputs req[NUM_CHANNELS] and rr_ptr;
  - outputs any and idx;
  - reused later by the fetcher arbiter.

Test Plan:
- Single read: ch1 read addr 0x3A; ext returns 0x5C after 3 cycles → ext_read_valid rises 1 cycle after request, address 0x3A, ch_read_ready[1]=1 with data 0x5C, cleared 1 cycle after ch1 drops valid.
- Round-robin: ch0–ch3 all reading continuously, rr_ptr=0 → grant order 0,1,2,3,0. No channel is starved, and wrap-around from 3→0 is verified.
- Same-channel read+write: ch2 read 0x10 and write 0x11←0xAA both valid → the read completes first and the write is issued in the next grant. ext_write_data=0xAA.
- Mixed contention: ch0 write 0x20←0x7F and ch3 read 0x21 together with rr_ptr=3 → ch3 read is granted first, then ch0 write. The two ext valids are never high simultaneously.
- Slow drain: ch1 holds read_valid 5 cycles after ready → arbiter stays in RD_DRAIN, busy=1, and no other grant is made until ch1 releases.
- Reset mid-read: assert reset during RD_WAIT → all outputs go 0 asynchronously. After release, the state is IDLE with rr_ptr=0, and a new request is served normally.
